// File: rtl/alu_muldiv.sv
// alu_muldiv: handshaked EX-stage ALU. Single-cycle logic/arith/shift/compare ops plus
// iterative shift-add multiply and restoring divide writing HI (high/remainder) and
// LO (low/quotient). One operation in flight; results held until the consumer takes them.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             div_by_zero
);

  // Counter must be able to hold the value WIDTH itself.
  localparam int unsigned CW = SHW + 1;

  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOr    = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpSltu  = 4'b0011;
  localparam logic [3:0] OpSll   = 4'b0100;
  localparam logic [3:0] OpSrl   = 4'b0101;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpSlt   = 4'b0111;
  localparam logic [3:0] OpSra   = 4'b1000;
  localparam logic [3:0] OpMult  = 4'b1001;
  localparam logic [3:0] OpMultu = 4'b1010;
  localparam logic [3:0] OpDiv   = 4'b1011;
  localparam logic [3:0] OpNor   = 4'b1100;
  localparam logic [3:0] OpXor   = 4'b1101;
  localparam logic [3:0] OpDivu  = 4'b1110;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;

  // Iteration datapath: acc holds product high half / partial remainder, wrk holds the
  // multiplier bits still to consume / dividend bits shifting into quotient bits.
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] wrk_q, wrk_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic             accept;
  logic             is_mul, is_div, is_sgn;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign out_valid   = (state_q == StDone);
  assign in_ready    = (state_q == StIdle) && !(out_valid && !out_ready);
  assign accept      = in_valid && in_ready;
  assign result      = result_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

  assign shamt  = data2[SHW-1:0];
  assign is_mul = (ALUControl == OpMult) || (ALUControl == OpMultu);
  assign is_div = (ALUControl == OpDiv) || (ALUControl == OpDivu);
  assign is_sgn = (ALUControl == OpMult) || (ALUControl == OpDiv);

  // Single-cycle ALU result, evaluated on the live operands at accept time.
  always_comb begin
    alu_res = '0;
    case (ALUControl)
      OpAnd:   alu_res = data1 & data2;
      OpOr:    alu_res = data1 | data2;
      OpAdd:   alu_res = data1 + data2;
      OpSub:   alu_res = data1 - data2;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (data1 < data2)};
      OpNor:   alu_res = ~(data1 | data2);
      OpXor:   alu_res = data1 ^ data2;
      OpSll:   alu_res = data1 << shamt;
      OpSrl:   alu_res = data1 >> shamt;
      OpSra:   alu_res = $unsigned($signed(data1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // One shift-add / restore step and the final sign correction of the magnitudes.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, bmag_q} : '0);
    div_sh   = {acc_q, wrk_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, bmag_q};
    prod_mag = {acc_q, wrk_q};
    prod_fix = negq_q ? -prod_mag : prod_mag;
    quo_fix  = negq_q ? -wrk_q : wrk_q;
    rem_fix  = negr_q ? -acc_q : acc_q;
  end

  // Next-state and datapath updates for the control FSM.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    a_raw_d  = a_raw_q;
    bmag_d   = bmag_q;
    acc_d    = acc_q;
    wrk_d    = wrk_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_raw_d = data1;
          bmag_d  = magnitude(data2, is_sgn);
          wrk_d   = magnitude(data1, is_sgn);
          acc_d   = '0;
          cnt_d   = '0;
          negq_d  = is_sgn && (data1[WIDTH-1] ^ data2[WIDTH-1]);
          negr_d  = is_sgn && data1[WIDTH-1];
          if (is_mul) begin
            state_d = StMul;
            dbz_d   = 1'b0;
          end else if (is_div) begin
            state_d = StDiv;
          end else begin
            state_d  = StDone;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            dbz_d    = 1'b0;
          end
        end
      end

      StMul: begin
        if (cnt_q == CW'(WIDTH)) begin
          hi_d     = prod_fix[2*WIDTH-1:WIDTH];
          lo_d     = prod_fix[WIDTH-1:0];
          result_d = prod_fix[WIDTH-1:0];
          zero_d   = (prod_fix[WIDTH-1:0] == '0);
          state_d  = StDone;
        end else begin
          acc_d = mul_sum[WIDTH:1];
          wrk_d = {mul_sum[0], wrk_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
        end
      end

      StDiv: begin
        if (cnt_q == CW'(WIDTH)) begin
          // Divide by zero overrides the iterated values with fixed results.
          if (bmag_q == '0) begin
            lo_d     = '1;
            hi_d     = a_raw_q;
            result_d = '1;
            zero_d   = 1'b0;
            dbz_d    = 1'b1;
          end else begin
            lo_d     = quo_fix;
            hi_d     = rem_fix;
            result_d = quo_fix;
            zero_d   = (quo_fix == '0);
            dbz_d    = 1'b0;
          end
          state_d = StDone;
        end else begin
          if (!div_diff[WIDTH]) begin
            acc_d = div_diff[WIDTH-1:0];
            wrk_d = {wrk_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_sh[WIDTH-1:0];
            wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
      a_raw_q  <= '0;
      bmag_q   <= '0;
      acc_q    <= '0;
      wrk_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      a_raw_q  <= a_raw_d;
      bmag_q   <= bmag_d;
      acc_q    <= acc_d;
      wrk_q    <= wrk_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed WIDTH=32 cases, backpressure, reset mid-divide,
// back-to-back issue, and randomised sweeps at WIDTH=16 and WIDTH=8 against a model.
module tb_alu_muldiv;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    logic        dbz;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    logic        dbz;
  } dir_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  int          sel = 0;  // 0: WIDTH=32, 1: WIDTH=16, 2: WIDTH=8
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  logic [3:0]  ctl = '0;

  logic ir32, ov32, z32, dz32;
  logic [31:0] r32, h32, l32;
  logic ir16, ov16, z16, dz16;
  logic [15:0] r16, h16, l16;
  logic ir8, ov8, z8, dz8;
  logic [7:0] r8, h8, l8;

  alu_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv && (sel == 0)), .in_ready(ir32),
    .data1(d1), .data2(d2), .ALUControl(ctl), .out_valid(ov32), .out_ready(ordy),
    .result(r32), .hi(h32), .lo(l32), .zero(z32), .div_by_zero(dz32)
  );

  alu_muldiv #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv && (sel == 1)), .in_ready(ir16),
    .data1(d1[15:0]), .data2(d2[15:0]), .ALUControl(ctl), .out_valid(ov16),
    .out_ready(ordy), .result(r16), .hi(h16), .lo(l16), .zero(z16), .div_by_zero(dz16)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv && (sel == 2)), .in_ready(ir8),
    .data1(d1[7:0]), .data2(d2[7:0]), .ALUControl(ctl), .out_valid(ov8),
    .out_ready(ordy), .result(r8), .hi(h8), .lo(l8), .zero(z8), .div_by_zero(dz8)
  );

  logic o_ready, o_valid, o_zero, o_dbz;
  logic [31:0] o_res, o_hi, o_lo;

  // Observe the selected DUT through one set of zero-extended signals.
  always_comb begin
    o_ready = ir32; o_valid = ov32; o_zero = z32; o_dbz = dz32;
    o_res = r32; o_hi = h32; o_lo = l32;
    if (sel == 1) begin
      o_ready = ir16; o_valid = ov16; o_zero = z16; o_dbz = dz16;
      o_res = {16'h0, r16}; o_hi = {16'h0, h16}; o_lo = {16'h0, l16};
    end else if (sel == 2) begin
      o_ready = ir8; o_valid = ov8; o_zero = z8; o_dbz = dz8;
      o_res = {24'h0, r8}; o_hi = {24'h0, h8}; o_lo = {24'h0, l8};
    end
  end

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  logic [31:0] mhi [3];
  logic [31:0] mlo [3];

  function automatic int wid(input int s);
    return (s == 0) ? 32 : ((s == 1) ? 16 : 8);
  endfunction

  function automatic logic is_md(input logic [3:0] op);
    return (op == 4'b1001) || (op == 4'b1010) || (op == 4'b1011) || (op == 4'b1110);
  endfunction

  // Reference model in 64-bit arithmetic, masked to width w.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int w, input logic [31:0] ohi, input logic [31:0] olo);
    exp_t e;
    logic [63:0] mask, ua, ub, r, p;
    longint sa, sb, sq, sr;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'h0, a} & mask;
    ub = {32'h0, b} & mask;
    sa = $signed(ua << (64 - w)) >>> (64 - w);
    sb = $signed(ub << (64 - w)) >>> (64 - w);
    sh = int'(ub & 64'(w - 1));
    e.hi = ohi; e.lo = olo; e.dbz = 1'b0; e.lat = 0; r = '0; p = '0;
    case (op)
      4'b0000: r = ua & ub;
      4'b0001: r = ua | ub;
      4'b0010: r = (ua + ub) & mask;
      4'b0110: r = (ua - ub) & mask;
      4'b0111: r = (sa < sb) ? 64'd1 : 64'd0;
      4'b0011: r = (ua < ub) ? 64'd1 : 64'd0;
      4'b1100: r = ~(ua | ub) & mask;
      4'b1101: r = ua ^ ub;
      4'b0100: r = (ua << sh) & mask;
      4'b0101: r = ua >> sh;
      4'b1000: r = 64'(sa >>> sh) & mask;
      4'b1001, 4'b1010: begin
        p = (op == 4'b1001) ? 64'(sa * sb) : ua * ub;
        e.hi = 32'((p >> w) & mask);
        e.lo = 32'(p & mask);
        r = p & mask;
        e.lat = w + 1;
      end
      4'b1011, 4'b1110: begin
        if (ub == 64'd0) begin
          e.lo = 32'(mask); e.hi = 32'(ua); e.dbz = 1'b1;
        end else if (op == 4'b1011) begin
          sq = sa / sb; sr = sa % sb;
          e.lo = 32'(64'(sq) & mask); e.hi = 32'(64'(sr) & mask);
        end else begin
          e.lo = 32'(ua / ub); e.hi = 32'(ua % ub);
        end
        r = {32'h0, e.lo};
        e.lat = w + 1;
      end
      default: r = '0;
    endcase
    e.res = 32'(r);
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; iv = 1'b0; ordy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin mhi[i] = '0; mlo[i] = '0; end
  endtask

  task automatic push_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(op, a, b, wid(sel), mhi[sel], mlo[sel]);
    mhi[sel] = e.hi; mlo[sel] = e.lo;
    sb_q.push_back(e);
  endtask

  // Present one request and hold it for exactly the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!o_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!o_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", o_ready);
    end
    ctl = op; d1 = a; d2 = b; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0; d1 = $urandom; d2 = $urandom; ctl = 4'($urandom);
  endtask

  // Wait for out_valid; lat = edges after the accept edge before it is seen.
  task automatic collect(output logic [31:0] res, output logic [31:0] h, output logic [31:0] l,
                         output logic z, output logic dz, output int lat);
    lat = 0;
    while (!o_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!o_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL collect_timeout: out_valid=%0b required 1", o_valid);
    end
    res = o_res; h = o_hi; l = o_lo; z = o_zero; dz = o_dbz;
  endtask

  task automatic release_out();
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      n_cmp++;
      if ({o_ready, o_valid, o_res, o_hi, o_lo, o_zero, o_dbz} !==
          {1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_w%0d: rdy=%b vld=%b res=%h hi=%h lo=%h z=%b dbz=%b, want 1 0 0 0 0 1 0",
                 wid(s), o_ready, o_valid, o_res, o_hi, o_lo, o_zero, o_dbz);
      end
    end
    sel = 0;
  endtask

  task automatic test_directed();
    dir_t tbl [19];
    exp_t e, x;
    int lat;
    tbl = '{
      '{4'b0010, 32'h7fffffff, 32'h1, 32'h80000000, 32'h0, 32'h0, 1'b0, 1'b0},
      '{4'b0110, 32'h5, 32'h5, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0},
      '{4'b0111, 32'hffffffff, 32'h1, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0},
      '{4'b0011, 32'hffffffff, 32'h1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0},
      '{4'b1000, 32'h80000000, 32'h4, 32'hf8000000, 32'h0, 32'h0, 1'b0, 1'b0},
      '{4'b0100, 32'h1, 32'h21, 32'h2, 32'h0, 32'h0, 1'b0, 1'b0},
      '{4'b0101, 32'h80000000, 32'h1f, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0},
      '{4'b1100, 32'h0, 32'h0, 32'hffffffff, 32'h0, 32'h0, 1'b0, 1'b0},
      '{4'b1101, 32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0, 32'h0, 32'h0, 1'b0, 1'b0},
      '{4'b0001, 32'h0f, 32'hf0, 32'hff, 32'h0, 32'h0, 1'b0, 1'b0},
      '{4'b0000, 32'h0f, 32'hf5, 32'h05, 32'h0, 32'h0, 1'b0, 1'b0},
      '{4'b1111, 32'h12345678, 32'h9, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0},
      '{4'b1001, 32'hfffffffd, 32'h7, 32'hffffffeb, 32'hffffffff, 32'hffffffeb, 1'b0, 1'b0},
      '{4'b1010, 32'hffffffff, 32'h2, 32'hfffffffe, 32'h1, 32'hfffffffe, 1'b0, 1'b0},
      '{4'b1011, 32'hfffffff9, 32'h2, 32'hfffffffd, 32'hffffffff, 32'hfffffffd, 1'b0, 1'b0},
      '{4'b1110, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 1'b0, 1'b0},
      '{4'b1011, 32'h80000000, 32'hffffffff, 32'h80000000, 32'h0, 32'h80000000, 1'b0, 1'b0},
      '{4'b1110, 32'd9, 32'd0, 32'hffffffff, 32'd9, 32'hffffffff, 1'b0, 1'b1},
      '{4'b0000, 32'h3, 32'h6, 32'h2, 32'd9, 32'hffffffff, 1'b0, 1'b0}
    };
    sel = 0;
    for (int i = 0; i < 19; i++) begin
      e.res = tbl[i].res; e.hi = tbl[i].hi; e.lo = tbl[i].lo;
      e.zero = tbl[i].zero; e.dbz = tbl[i].dbz;
      e.lat = is_md(tbl[i].op) ? 33 : 0;
      sb_q.push_back(e);
      send(tbl[i].op, tbl[i].a, tbl[i].b);
      collect(x.res, x.hi, x.lo, x.zero, x.dbz, lat);
      e = sb_q.pop_front();
      n_cmp++;
      if ({x.res, x.hi, x.lo, x.zero, x.dbz} !== {e.res, e.hi, e.lo, e.zero, e.dbz}) begin
        n_fail++;
        $display("FAIL dir%0d_op%b: got res=%h hi=%h lo=%h z=%b dbz=%b, want res=%h hi=%h lo=%h z=%b dbz=%b",
                 i, tbl[i].op, x.res, x.hi, x.lo, x.zero, x.dbz, e.res, e.hi, e.lo, e.zero, e.dbz);
      end
      n_cmp++;
      if (lat != e.lat) begin
        n_fail++;
        $display("FAIL dir%0d_latency: got %0d edges, want %0d", i, lat, e.lat);
      end
      release_out();
    end
    mhi[0] = 32'd9; mlo[0] = 32'hffffffff;
  endtask

  task automatic test_backpressure();
    exp_t e, x;
    int lat;
    sel = 0;
    e.res = 32'h0; e.hi = 32'h1; e.lo = 32'h0; e.zero = 1'b1; e.dbz = 1'b0; e.lat = 33;
    sb_q.push_back(e);
    send(4'b1001, 32'h00010000, 32'h00010000);
    collect(x.res, x.hi, x.lo, x.zero, x.dbz, lat);
    e = sb_q.pop_front();
    n_cmp++;
    if ({x.res, x.hi, x.lo, x.zero, x.dbz, lat} !== {e.res, e.hi, e.lo, e.zero, e.dbz, e.lat}) begin
      n_fail++;
      $display("FAIL bp_mult: got res=%h hi=%h lo=%h z=%b lat=%0d, want res=%h hi=%h lo=%h z=%b lat=%0d",
               x.res, x.hi, x.lo, x.zero, lat, e.res, e.hi, e.lo, e.zero, e.lat);
    end
    // Stall the consumer and offer a competing request that must be ignored.
    ctl = 4'b0010; d1 = 32'h1; d2 = 32'h1; iv = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({o_valid, o_ready, o_res, o_hi, o_lo, o_zero, o_dbz} !==
          {1'b1, 1'b0, e.res, e.hi, e.lo, e.zero, e.dbz}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b res=%h hi=%h lo=%h z=%b, want 1 0 %h %h %h %b",
                 k, o_valid, o_ready, o_res, o_hi, o_lo, o_zero, e.res, e.hi, e.lo, e.zero);
      end
    end
    iv = 1'b0;
    release_out();
    n_cmp++;
    if ({o_valid, o_ready, o_hi, o_lo} !== {1'b0, 1'b1, 32'h1, 32'h0}) begin
      n_fail++;
      $display("FAIL bp_release: vld=%b rdy=%b hi=%h lo=%h, want 0 1 00000001 00000000",
               o_valid, o_ready, o_hi, o_lo);
    end
    mhi[0] = 32'h1; mlo[0] = 32'h0;
  endtask

  task automatic test_reset_mid_div();
    int seen = 0;
    sel = 0;
    send(4'b1110, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    n_cmp++;
    if ({o_valid, o_ready, o_hi, o_lo, o_res, o_zero, o_dbz} !==
        {1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_div: vld=%b rdy=%b hi=%h lo=%h res=%h z=%b dbz=%b, want 0 1 0 0 0 1 0",
               o_valid, o_ready, o_hi, o_lo, o_res, o_zero, o_dbz);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_abandon: out_valid seen %0d cycles, want 0", seen);
    end
    for (int i = 0; i < 3; i++) begin mhi[i] = '0; mlo[i] = '0; end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sel = 0;
    ordy = 1'b1;
    ctl = 4'b0010; d1 = 32'd1; d2 = 32'd2; iv = 1'b1;
    push_model(4'b0010, 32'd1, 32'd2);
    @(posedge clk); #1;
    ctl = 4'b0110; d1 = 32'd9; d2 = 32'd4;
    push_model(4'b0110, 32'd9, 32'd4);
    e = sb_q.pop_front();
    n_cmp++;
    if ({o_valid, o_ready, o_res} !== {1'b1, 1'b0, e.res}) begin
      n_fail++;
      $display("FAIL b2b_first: vld=%b rdy=%b res=%h, want 1 0 %h", o_valid, o_ready, o_res, e.res);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({o_valid, o_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_gap: vld=%b rdy=%b, want 0 1", o_valid, o_ready);
    end
    @(posedge clk); #1;
    iv = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if ({o_valid, o_res, o_zero} !== {1'b1, e.res, e.zero}) begin
      n_fail++;
      $display("FAIL b2b_second: vld=%b res=%h z=%b, want 1 %h %b", o_valid, o_res, o_zero, e.res, e.zero);
    end
    @(posedge clk); #1;
    ordy = 1'b0;
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = 32'((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'h1 << (w - 1);
      2:       return m;
      3:       return 32'($urandom_range(1, 3));
      default: return $urandom & m;
    endcase
  endfunction

  task automatic test_sweep();
    exp_t e, x;
    logic [3:0] op;
    logic [31:0] a, b;
    int lat;
    for (int s = 1; s < 3; s++) begin
      sel = s;
      do_reset();
      for (int k = 0; k < 40; k++) begin
        op = 4'($urandom_range(0, 15));
        a = pick(wid(s));
        b = pick(wid(s));
        push_model(op, a, b);
        send(op, a, b);
        collect(x.res, x.hi, x.lo, x.zero, x.dbz, lat);
        e = sb_q.pop_front();
        n_cmp++;
        if ({x.res, x.hi, x.lo, x.zero, x.dbz} !== {e.res, e.hi, e.lo, e.zero, e.dbz}) begin
          n_fail++;
          $display("FAIL sweep_w%0d_%0d op=%b a=%h b=%h: got res=%h hi=%h lo=%h z=%b dbz=%b, want res=%h hi=%h lo=%h z=%b dbz=%b",
                   wid(s), k, op, a, b, x.res, x.hi, x.lo, x.zero, x.dbz,
                   e.res, e.hi, e.lo, e.zero, e.dbz);
        end
        n_cmp++;
        if (lat != e.lat) begin
          n_fail++;
          $display("FAIL sweep_w%0d_%0d_latency op=%b: got %0d edges, want %0d",
                   wid(s), k, op, lat, e.lat);
        end
        release_out();
      end
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_div();
    test_back_to_back();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
